ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 60 ++++++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: state encoding, glitch-filter length and timing helper shared by
// the PS/2 host transmitter and its line synchronizer.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE
    } ps2_state_e;

    localparam int PS2_FILTER_LEN = 8;

    function automatic int cycles_per_us(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer, optional level filter
// (PS2_TX_GLITCH_FILTER_EN) and registered falling-edge detect for one PS/2 line.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic s1, s2, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= pad;
            s2 <= s1;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FW = $clog2(PS2_FILTER_LEN);
    logic [FW-1:0] run;
    logic          filt;

    // A new level is taken only after it has been seen on every sample of a full run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= '0;
            filt <= 1'b1;
        end else if (s2 == filt) begin
            run <= '0;
        end else if (run == FW'(PS2_FILTER_LEN - 1)) begin
            run  <= '0;
            filt <= s2;
        end else begin
            run <= run + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
            fall <= 1'b0;
        end else begin
            prev <= level;
            fall <= prev & ~level;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send,
// 8 data + odd parity + stop, ACK check, timeout). Option: PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_CYC = cycles_per_us(CLK_FREQ_HZ) * INHIBIT_US;
    localparam int TO_CYC  = cycles_per_us(CLK_FREQ_HZ) * TIMEOUT_US;
    localparam int IW      = $clog2(INH_CYC + 1);
    localparam int TW      = $clog2(TO_CYC + 1);

    ps2_state_e    state, state_d;
    logic [7:0]    sh, sh_d;
    logic          par, par_d;
    logic [2:0]    cnt, cnt_d;
    logic [IW-1:0] tmr, tmr_d;
    logic [TW-1:0] tocnt, tocnt_d;
    logic          doe, doe_d;
    logic          rel, rel_d;
    logic          done_d, err_d;
    logic          rdy_en;
    logic          clk_lvl, clk_fall, data_lvl, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (ps2_clk_in),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (ps2_data_in),
        .level (data_lvl),
        .fall  (data_fall_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sh      <= '0;
            par     <= 1'b0;
            cnt     <= '0;
            tmr     <= '0;
            tocnt   <= '0;
            doe     <= 1'b0;
            rel     <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            rdy_en  <= 1'b0;
        end else begin
            state   <= state_d;
            sh      <= sh_d;
            par     <= par_d;
            cnt     <= cnt_d;
            tmr     <= tmr_d;
            tocnt   <= tocnt_d;
            doe     <= doe_d;
            rel     <= rel_d;
            tx_done <= done_d;
            tx_err  <= err_d;
            rdy_en  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        sh_d    = sh;
        par_d   = par;
        cnt_d   = cnt;
        tmr_d   = tmr;
        tocnt_d = tocnt;
        doe_d   = doe;
        rel_d   = rel;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            S_IDLE: begin
                doe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    sh_d    = tx_data;
                    par_d   = ~^tx_data;
                    tmr_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            // The first REQ cycle still holds the clock, so INHIBIT itself is one
            // cycle short and the clock stays low for exactly INH_CYC cycles.
            S_INHIBIT: begin
                tmr_d = tmr + 1'b1;
                if (tmr == IW'(INH_CYC - 2)) begin
                    doe_d   = 1'b1;
                    rel_d   = 1'b0;
                    tocnt_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                rel_d = 1'b1;
                if (rel && clk_fall) begin
                    doe_d   = ~sh[0];
                    sh_d    = sh >> 1;
                    cnt_d   = 3'd1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (clk_fall) begin
                    doe_d = ~sh[0];
                    sh_d  = sh >> 1;
                    cnt_d = cnt + 3'd1;
                    if (cnt == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (clk_fall) begin
                    doe_d   = ~par;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_fall) begin
                    doe_d   = 1'b0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    if (!data_lvl) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame watchdog overrides whatever the bit sequencer decided.
        if (state inside {S_REQ, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE}) begin
            if (tocnt == TW'(TO_CYC - 1)) begin
                state_d = S_IDLE;
                doe_d   = 1'b0;
                done_d  = 1'b0;
                err_d   = 1'b1;
            end else begin
                tocnt_d = tocnt + 1'b1;
            end
        end
    end

    assign tx_ready    = (state == S_IDLE) && rdy_en;
    assign busy        = (state != S_IDLE);
    assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ && !rel);
    assign ps2_data_oe = doe;

endmodule
